// File: rtl/alu_sched_pkg.sv
// Shared constants, state encoding and request payload for the serial ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned ALU_BITS = 4;
  localparam int unsigned OPW      = 3;

  localparam logic [OPW-1:0] OP_RESET = 3'b000;
  localparam logic [OPW-1:0] OP_XOR   = 3'b001;
  localparam logic [OPW-1:0] OP_SUB   = 3'b010;
  localparam logic [OPW-1:0] OP_NAND  = 3'b011;
  localparam logic [OPW-1:0] OP_ADD   = 3'b100;

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, RESP} state_t;

  typedef struct packed {
    logic [ALU_BITS-1:0] a;
    logic [ALU_BITS-1:0] b;
    logic [OPW-1:0]      op;
  } alu_req_t;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_XOR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  int idx;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(ptr) + k) % int'(NREQ);
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_serial_sched.sv
// Round-robin scheduler driving one shared bit-serial ALU: CLR, 4 RUN cycles, CAPT, RESP.
// Optional ALU_SCHED_STATS_EN adds saturating response counters stat_ops/stat_err.
module alu_serial_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [4*NREQ-1:0]      req_a,
  input  logic [4*NREQ-1:0]      req_b,
  input  logic [3*NREQ-1:0]      req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [ALU_BITS-1:0]    rsp_c,
  output logic                   rsp_zf,
  output logic                   rsp_cf,
  output logic                   rsp_sf,
  output logic                   rsp_err,
  output logic [ALU_BITS-1:0]    alu_a,
  output logic [ALU_BITS-1:0]    alu_b,
  output logic [OPW-1:0]         alu_opcode,
  input  logic [ALU_BITS-1:0]    alu_c,
  input  logic                   alu_zf,
  input  logic                   alu_cf,
  input  logic                   alu_sf
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_err
`endif
);

  localparam int unsigned CNTW = $clog2(ALU_BITS);

  state_t              state_q, state_n;
  logic [CNTW-1:0]     cnt_q, cnt_n;
  logic [IDW-1:0]      rr_q, rr_n;
  logic [OPW-1:0]      op_q, op_n;
  logic                live_q;
  logic [OPW-1:0]      opc_n;
  logic [ALU_BITS-1:0] a_n, b_n, c_n;
  logic [IDW-1:0]      id_n;
  logic                vld_n, zf_n, cf_n, sf_n, err_n;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      gnt_id;
  logic                gnt_any;
  logic                accept;
  alu_req_t            sel;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid  (req_valid),
    .ptr    (rr_q),
    .grant  (grant),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Same-cycle grant so ready can only ever pair with a live req_valid; live_q masks the reset-release cycle.
  assign req_ready = (state_q == IDLE && live_q) ? grant : '0;
  assign accept    = (state_q == IDLE) && live_q && gnt_any;

  assign sel.a  = req_a[int'(gnt_id)*ALU_BITS +: ALU_BITS];
  assign sel.b  = req_b[int'(gnt_id)*ALU_BITS +: ALU_BITS];
  assign sel.op = req_op[int'(gnt_id)*OPW +: OPW];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rr_n    = rr_q;
    op_n    = op_q;
    opc_n   = alu_opcode;
    a_n     = alu_a;
    b_n     = alu_b;
    vld_n   = rsp_valid;
    id_n    = rsp_id;
    c_n     = rsp_c;
    zf_n    = rsp_zf;
    cf_n    = rsp_cf;
    sf_n    = rsp_sf;
    err_n   = rsp_err;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_n  = sel.a;
          b_n  = sel.b;
          op_n = sel.op;
          id_n = gnt_id;
          rr_n = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
          if (op_legal(sel.op)) begin
            state_n = CLR;
            opc_n   = OP_RESET;
            err_n   = 1'b0;
          end else begin
            state_n = RESP;
            err_n   = 1'b1;
            c_n     = '0;
            zf_n    = 1'b0;
            cf_n    = 1'b0;
            sf_n    = 1'b0;
          end
        end
      end
      CLR: begin
        state_n = RUN;
        cnt_n   = '0;
        opc_n   = op_q;
      end
      RUN: begin
        cnt_n = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(ALU_BITS - 1)) begin
          state_n = CAPT;
          opc_n   = OP_RESET;
        end
      end
      CAPT: begin
        c_n     = alu_c;
        zf_n    = alu_zf;
        cf_n    = alu_cf;
        sf_n    = alu_sf;
        vld_n   = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        // Error responses enter RESP with valid low and raise it one edge later.
        if (!rsp_valid) begin
          vld_n = 1'b1;
        end else if (rsp_ready) begin
          vld_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= '0;
      op_q       <= OP_RESET;
      live_q     <= 1'b0;
      alu_opcode <= OP_RESET;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_c      <= '0;
      rsp_zf     <= 1'b0;
      rsp_cf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      rr_q       <= rr_n;
      op_q       <= op_n;
      live_q     <= 1'b1;
      alu_opcode <= opc_n;
      alu_a      <= a_n;
      alu_b      <= b_n;
      rsp_valid  <= vld_n;
      rsp_id     <= id_n;
      rsp_c      <= c_n;
      rsp_zf     <= zf_n;
      rsp_cf     <= cf_n;
      rsp_sf     <= sf_n;
      rsp_err    <= err_n;
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state_q == RESP) && rsp_valid && rsp_ready;

  // Saturating counts of completed legal and error responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (rsp_hs) begin
      if (rsp_err) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else if (stat_ops != 16'hFFFF) begin
        stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule
